// File: rtl/ifmap_buf_ctrl.sv
// Sequencer for the FC-layer ifmap buffer: loads one vector from an input stream,
// then replays it a configured number of passes to the MAC array.
//
// state  | meaning
// IDLE   | waiting for start_i; latches len/rep
// LOAD   | accepting len input bytes into buffer addresses 0..len-1
// STREAM | reading buffer 0..len-1 per pass, rep passes, valid/ready output
// DONE   | one-cycle done_o pulse, then back to IDLE
module ifmap_buf_ctrl #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int LW    = 8,
    parameter int RW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [LW-1:0] cfg_len_i,
    input  logic [RW-1:0] cfg_rep_i,
    output logic          busy_o,
    output logic          done_o,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic          out_last_o,
    output logic          buf_rden_o,
    output logic          buf_wren_o,
    output logic [AW-1:0] buf_rdptr_o,
    output logic [AW-1:0] buf_wrptr_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [1:0]    state;
    logic [LW-1:0] len;
    logic [RW-1:0] passes_left;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_idx;
    logic          out_valid;
    logic          out_last;

    logic [LW-1:0] len_clamped;
    logic [LW-1:0] len_m1;
    logic          wr_last;
    logic          rd_last;
    logic          reads_left;
    logic          issue;
    logic          accept_in;
    logic          accept_out;

    assign len_clamped = (cfg_len_i > DEPTH_L) ? DEPTH_L : cfg_len_i;
    assign len_m1      = len - LW'(1);
    assign wr_last     = (LW'(wr_cnt) == len_m1);
    assign rd_last     = (LW'(rd_idx) == len_m1);
    // passes_left counts passes whose final index has not been issued yet
    assign reads_left  = (passes_left != '0);
    assign issue       = (state == S_STREAM) && reads_left && (!out_valid || out_ready_i);
    assign accept_in   = (state == S_LOAD) && in_valid_i;
    assign accept_out  = out_valid && out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            len         <= '0;
            passes_left <= '0;
            wr_cnt      <= '0;
            rd_idx      <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        len         <= len_clamped;
                        passes_left <= cfg_rep_i;
                        state       <= (len_clamped == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept_in) begin
                        if (wr_last) begin
                            wr_cnt <= '0;
                            state  <= (passes_left == '0) ? S_DONE : S_STREAM;
                        end else begin
                            wr_cnt <= wr_cnt + AW'(1);
                        end
                    end
                end
                S_STREAM: begin
                    if (issue) begin
                        if (rd_last) begin
                            rd_idx      <= '0;
                            passes_left <= passes_left - RW'(1);
                        end else begin
                            rd_idx <= rd_idx + AW'(1);
                        end
                    end
                    if (accept_out && out_last && !reads_left) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Buffer read latency is one cycle, so valid/last follow the issue by one cycle
            if (issue) begin
                out_valid <= 1'b1;
                out_last  <= rd_last;
            end else if (accept_out) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign busy_o      = (state != S_IDLE);
    assign done_o      = (state == S_DONE);
    assign in_ready_o  = (state == S_LOAD);
    assign buf_wren_o  = accept_in;
    assign buf_wrptr_o = (state == S_LOAD) ? wr_cnt : '0;
    assign buf_rden_o  = issue;
    assign buf_rdptr_o = (state == S_STREAM) ? rd_idx : '0;
    assign out_valid_o = out_valid;
    assign out_last_o  = out_last;

endmodule

// File: tb/tb_ifmap_buf_ctrl.sv
// Bench for ifmap_buf_ctrl: models the single-port buffer, issues directed jobs and
// checks the replayed stream against a scoreboard filled when each job is issued.
module tb_ifmap_buf_ctrl;

    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int LW    = 8;
    localparam int RW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [LW-1:0] cfg_len_i;
    logic [RW-1:0] cfg_rep_i;
    logic          busy_o;
    logic          done_o;
    logic          in_valid_i;
    logic          in_ready_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          out_last_o;
    logic          buf_rden_o;
    logic          buf_wren_o;
    logic [AW-1:0] buf_rdptr_o;
    logic [AW-1:0] buf_wrptr_o;

    logic [7:0] in_data;
    logic [7:0] mem [DEPTH];
    logic [7:0] buf_dout;
    logic [7:0] job_data [DEPTH];

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb_q[$];

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int mod_len = 1;
    int wr_seen = 0;
    int rd_seen = 0;
    int done_seen = 0;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_dout = 8'h00;
    logic       prev_last = 1'b0;

    ifmap_buf_ctrl #(.DEPTH(DEPTH), .AW(AW), .LW(LW), .RW(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .cfg_len_i   (cfg_len_i),
        .cfg_rep_i   (cfg_rep_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_last_o  (out_last_o),
        .buf_rden_o  (buf_rden_o),
        .buf_wren_o  (buf_wren_o),
        .buf_rdptr_o (buf_rdptr_o),
        .buf_wrptr_o (buf_wrptr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port buffer with one-cycle read latency; dout holds when rden is low
    always @(posedge clk) begin
        if (buf_wren_o) mem[buf_wrptr_o] <= in_data;
        if (buf_rden_o) buf_dout <= mem[buf_rdptr_o];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) out_ready_i = ~out_ready_i;
            else out_ready_i = 1'b1;
        end
    end

    // Monitor: per-cycle invariants plus scoreboard pop on every output handshake
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            exp_t e;
            check("wren_rden_overlap", 32'(buf_wren_o && buf_rden_o), 0);
            if (in_ready_o)
                check("in_ready_outside_load", 32'(out_valid_o | buf_rden_o | done_o | !busy_o), 0);
            if (!busy_o)
                check("idle_ptrs", 32'({buf_wrptr_o, buf_rdptr_o}), 0);
            if (buf_wren_o) begin
                check("wrptr_order", 32'(buf_wrptr_o), wr_seen);
                wr_seen++;
            end
            if (buf_rden_o) begin
                check("rdptr_order", 32'(buf_rdptr_o), rd_seen % mod_len);
                rd_seen++;
            end
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid_o), 1);
                check("stall_data", 32'(buf_dout), 32'(prev_dout));
                check("stall_last", 32'(out_last_o), 32'(prev_last));
            end
            if (out_valid_o && !out_ready_i)
                check("rden_while_stalled", 32'(buf_rden_o), 0);
            if (done_o) done_seen++;
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL sb_underflow: output byte %0h with no expected entry (cycle %0d)",
                             buf_dout, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", 32'(buf_dout), 32'(e.data));
                    check("out_last", 32'(out_last_o), 32'(e.last));
                end
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_dout  = buf_dout;
            prev_last  = out_last_o;
        end
    end

    task automatic check_all_zero(input string name);
        check(name, 32'({busy_o, done_o, in_ready_o, out_valid_o, out_last_o,
                         buf_rden_o, buf_wren_o, buf_rdptr_o, buf_wrptr_o}), 0);
    endtask

    task automatic run_job(input int len_cfg, input int rep, input int stall, input int gaps,
                           input int inject, input int timed, input int abort_at);
        int   eff;
        int   k;
        int   t;
        int   c0;
        int   exp_lat;
        logic acc;
        exp_t e;
        eff = (len_cfg > DEPTH) ? DEPTH : len_cfg;
        for (int p = 0; p < rep; p++) begin
            for (int i = 0; i < eff; i++) begin
                e.data = job_data[i];
                e.last = (i == eff - 1);
                sb_q.push_back(e);
            end
        end
        mod_len   = (eff == 0) ? 1 : eff;
        wr_seen   = 0;
        rd_seen   = 0;
        done_seen = 0;
        rdy_mode  = stall;
        exp_lat   = (eff == 0) ? 1 : ((rep == 0) ? eff + 1 : eff * rep + eff + 2);

        @(posedge clk);
        #1;
        c0         = cyc;
        cfg_len_i  = len_cfg[LW-1:0];
        cfg_rep_i  = rep[RW-1:0];
        start_i    = 1'b1;
        in_valid_i = 1'b0;
        in_data    = job_data[0];
        @(posedge clk);
        #1;
        start_i = 1'b0;

        k = 0;
        t = 0;
        while (k < eff && t < 2000) begin
            in_valid_i = (gaps == 0) || (t % 3 != 1);
            in_data    = job_data[k];
            acc        = in_ready_o && in_valid_i;
            @(posedge clk);
            #1;
            t++;
            if (acc) k++;
        end
        in_valid_i = 1'b0;
        if (k < eff) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL load_timeout: accepted %0d of %0d bytes", k, eff);
        end

        t = 0;
        while (!done_o && t < 3000) begin
            if (inject != 0) begin
                if (t == 3) begin
                    start_i   = 1'b1;
                    cfg_len_i = 8'd2;
                    cfg_rep_i = 8'd1;
                end else begin
                    start_i = 1'b0;
                end
            end
            if (abort_at > 0 && t == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                check_all_zero("reset_mid_stream_outputs");
                rst = 1'b0;
                sb_q.delete();
                rdy_mode = 0;
                repeat (6) begin
                    @(posedge clk);
                    #1;
                end
                check("abort_no_done", done_seen, 0);
                check("abort_idle", 32'(busy_o), 0);
                return;
            end
            @(posedge clk);
            #1;
            t++;
        end
        start_i = 1'b0;

        if (!done_o) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL done_timeout: no done_o after %0d cycles", t);
        end else if (timed != 0) begin
            check("job_latency", cyc - c0, exp_lat);
        end
        @(posedge clk);
        #1;
        check("done_pulse_width", 32'(done_o), 0);
        check("idle_after_done", 32'(busy_o), 0);
        check("done_count", done_seen, 1);
        check("sb_drained", sb_q.size(), 0);
        check("write_count", wr_seen, eff);
        check("read_count", rd_seen, eff * rep);
        rdy_mode = 0;
        sb_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        cfg_len_i  = '0;
        cfg_rep_i  = '0;
        in_valid_i = 1'b0;
        in_data    = 8'h00;
        for (int i = 0; i < DEPTH; i++) job_data[i] = 8'h00;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_all_zero("reset_outputs_in_reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset_outputs_after_release");

        job_data[0] = 8'h11;
        job_data[1] = 8'h22;
        job_data[2] = 8'h33;
        job_data[3] = 8'h44;
        // len=4 rep=2, full throughput, latency 4*2+4+2
        run_job(4, 2, 0, 0, 0, 1, 0);
        // same job with 1010 ready pattern and a start pulse ignored mid-stream
        run_job(4, 2, 1, 0, 1, 0, 0);

        for (int i = 0; i < DEPTH; i++) job_data[i] = 8'(i * 7 + 3);
        // len=200 clamps to 128
        run_job(200, 1, 0, 0, 0, 1, 0);

        // len=0: done one cycle after the start cycle, no buffer traffic
        run_job(0, 5, 0, 0, 0, 1, 0);
        // rep=0: load only
        run_job(3, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 5; i++) job_data[i] = 8'(8'hA0 + i);
        // input gaps plus output stalls across pass boundaries
        run_job(5, 3, 1, 1, 0, 0, 0);

        // reset asserted mid-STREAM
        run_job(4, 3, 0, 0, 0, 0, 5);

        job_data[0] = 8'h5A;
        job_data[1] = 8'hC3;
        run_job(2, 1, 0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
